// File: rtl/point_pkg.sv
// Shared point-link definitions: beat/point geometry, the packed point layout
// (common with the formatter) and the parser state encoding.
package point_pkg;

  localparam int unsigned POINT_W         = 128;
  localparam int unsigned BEAT_W          = 32;
  localparam int unsigned BEATS_PER_POINT = 4;
  localparam int unsigned COORD_W         = 32;
  localparam int unsigned CHAN_W          = 8;

  // x occupies the MSW, so it travels as the first beat on the link.
  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] z;
    logic [CHAN_W-1:0]  r;
    logic [CHAN_W-1:0]  g;
    logic [CHAN_W-1:0]  b;
    logic [CHAN_W-1:0]  intensity;
  } point_t;

  typedef enum logic [0:0] {
    ASSEMBLE = 1'b0,
    DISCARD  = 1'b1
  } parser_state_e;

endpackage

// File: rtl/point_parser_if.sv
// Point parser bus: beat stream in (valid/ready/last) and split point fields out
// (valid/ready). master = link/consumer side, slave = parser side.
interface point_parser_if;
  import point_pkg::*;

  logic [BEAT_W-1:0]  in_data;
  logic               in_valid;
  logic               in_last;
  logic               in_ready;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic [COORD_W-1:0] z;
  logic [CHAN_W-1:0]  r;
  logic [CHAN_W-1:0]  g;
  logic [CHAN_W-1:0]  b;
  logic [CHAN_W-1:0]  intensity;
  logic               out_valid;
  logic               out_ready;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, x, y, z, r, g, b, intensity, out_valid
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, x, y, z, r, g, b, intensity, out_valid
  );

endinterface

// File: rtl/point_field_splitter.sv
// Combinational split of a packed point into its fields, with an optional
// coordinate range check (enabled by POINT_PARSER_RANGE_CHECK_EN).
module point_field_splitter
  import point_pkg::*;
#(
  parameter logic [COORD_W-1:0] MAX_RANGE = 32'h0010_0000
) (
  input  point_t             pt,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic [COORD_W-1:0] z,
  output logic [CHAN_W-1:0]  r,
  output logic [CHAN_W-1:0]  g,
  output logic [CHAN_W-1:0]  b,
  output logic [CHAN_W-1:0]  intensity,
  output logic               in_range
);

  assign x         = pt.x;
  assign y         = pt.y;
  assign z         = pt.z;
  assign r         = pt.r;
  assign g         = pt.g;
  assign b         = pt.b;
  assign intensity = pt.intensity;

`ifdef POINT_PARSER_RANGE_CHECK_EN
  // Unsigned magnitude; -2^31 maps to 0x8000_0000, which is always out of range.
  function automatic logic [COORD_W-1:0] abs_val(input logic [COORD_W-1:0] v);
    return v[COORD_W-1] ? (~v + COORD_W'(1)) : v;
  endfunction

  assign in_range = (abs_val(pt.x) <= MAX_RANGE) &&
                    (abs_val(pt.y) <= MAX_RANGE) &&
                    (abs_val(pt.z) <= MAX_RANGE);
`else
  logic [COORD_W-1:0] unused_max_range;
  assign unused_max_range = MAX_RANGE;
  assign in_range         = 1'b1;
`endif

endmodule

// File: rtl/point_parser.sv
// Point parser: reassembles 4x32-bit beats into a 128-bit point, checks framing
// against in_last, and presents the split fields on a registered valid/ready port.
// Optional range-based point dropping via POINT_PARSER_RANGE_CHECK_EN.
module point_parser
  import point_pkg::*;
#(
  parameter int unsigned        ERR_CNT_W = 8,
  parameter int unsigned        PT_CNT_W  = 16,
  parameter logic [COORD_W-1:0] MAX_RANGE = 32'h0010_0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  point_parser_if.slave        bus,
  output logic                 frame_err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [PT_CNT_W-1:0]  point_count,
  output logic [15:0]          drop_count
);

  parser_state_e        state_q, state_d;
  logic [1:0]           beat_q, beat_d;
  logic [3*BEAT_W-1:0]  asm_q, asm_d;
  point_t               out_q, cand, split_pt;
  logic                 out_valid_q, out_valid_d;
  logic                 accept, complete, load, err, handoff, range_ok;
  logic                 frame_err_q;
  logic [ERR_CNT_W-1:0] err_count_q;
  logic [PT_CNT_W-1:0]  point_count_q;
  logic [COORD_W-1:0]   sx, sy, sz;
  logic [CHAN_W-1:0]    sr, sg, sb, si;

  // Only a pending final beat may stall on a full, unconsumed output register.
  assign bus.in_ready = !(state_q == ASSEMBLE && beat_q == 2'd3 && out_valid_q && !bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign handoff      = out_valid_q && bus.out_ready;
  assign cand         = point_t'({asm_q, bus.in_data});
  assign load         = complete && range_ok;

  point_field_splitter #(
    .MAX_RANGE (MAX_RANGE)
  ) u_splitter (
    .pt        (cand),
    .x         (sx),
    .y         (sy),
    .z         (sz),
    .r         (sr),
    .g         (sg),
    .b         (sb),
    .intensity (si),
    .in_range  (range_ok)
  );

  assign split_pt = '{x: sx, y: sy, z: sz, r: sr, g: sg, b: sb, intensity: si};

  // Framing FSM: beat counting, assembly shifting and error detection.
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    asm_d    = asm_q;
    complete = 1'b0;
    err      = 1'b0;
    if (accept) begin
      case (state_q)
        ASSEMBLE: begin
          if (beat_q != 2'd3) begin
            if (bus.in_last) begin
              err    = 1'b1;
              beat_d = '0;
            end else begin
              asm_d  = {asm_q[2*BEAT_W-1:0], bus.in_data};
              beat_d = beat_q + 2'd1;
            end
          end else begin
            beat_d = '0;
            if (bus.in_last) begin
              complete = 1'b1;
            end else begin
              err     = 1'b1;
              state_d = DISCARD;
            end
          end
        end
        DISCARD: begin
          if (bus.in_last) begin
            state_d = ASSEMBLE;
            beat_d  = '0;
          end
        end
        default: state_d = ASSEMBLE;
      endcase
    end
  end

  // A load in the handoff cycle wins over the clear.
  always_comb begin
    out_valid_d = out_valid_q;
    if (load) begin
      out_valid_d = 1'b1;
    end else if (handoff) begin
      out_valid_d = 1'b0;
    end
  end

  // Framing state and assembly register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ASSEMBLE;
      beat_q  <= '0;
      asm_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      asm_q   <= asm_d;
    end
  end

  // Output register, held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      if (load) begin
        out_q <= split_pt;
      end
    end
  end

  // Error pulse, saturating error count and wrapping handoff count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err_q   <= 1'b0;
      err_count_q   <= '0;
      point_count_q <= '0;
    end else begin
      frame_err_q <= err;
      if (err && err_count_q != '1) begin
        err_count_q <= err_count_q + ERR_CNT_W'(1);
      end
      if (handoff) begin
        point_count_q <= point_count_q + PT_CNT_W'(1);
      end
    end
  end

`ifdef POINT_PARSER_RANGE_CHECK_EN
  logic [15:0] drop_q;

  // Saturating count of completed points rejected by the range check.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= '0;
    end else if (complete && !range_ok && drop_q != '1) begin
      drop_q <= drop_q + 16'd1;
    end
  end

  assign drop_count = drop_q;
`else
  assign drop_count = '0;
`endif

  assign bus.out_valid = out_valid_q;
  assign bus.x         = out_q.x;
  assign bus.y         = out_q.y;
  assign bus.z         = out_q.z;
  assign bus.r         = out_q.r;
  assign bus.g         = out_q.g;
  assign bus.b         = out_q.b;
  assign bus.intensity = out_q.intensity;
  assign frame_err     = frame_err_q;
  assign err_count     = err_count_q;
  assign point_count   = point_count_q;

endmodule

// File: tb/tb_point_parser.sv
// Directed bench for point_parser with a queue scoreboard of expected points.
// The point counter is narrowed so that its wrap is reachable in a short run.
module tb_point_parser;
  import point_pkg::*;

  localparam int unsigned PT_W  = 6;
  localparam int unsigned ERR_W = 8;

  logic             clk;
  logic             rst_n;
  logic             frame_err;
  logic [ERR_W-1:0] err_count;
  logic [PT_W-1:0]  point_count;
  logic [15:0]      drop_count;

  point_parser_if bus ();

  point_parser #(
    .ERR_CNT_W (ERR_W),
    .PT_CNT_W  (PT_W),
    .MAX_RANGE (32'h0010_0000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .frame_err   (frame_err),
    .err_count   (err_count),
    .point_count (point_count),
    .drop_count  (drop_count)
  );

  int     total = 0;
  int     bad   = 0;
  int     exp_pc = 0;
  int     fe_seen = 0;
  int     cyc = 0;
  point_t exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] out_fields();
    return {bus.x, bus.y, bus.z, bus.r, bus.g, bus.b, bus.intensity};
  endfunction

  // Scoreboard: a handoff happens at the next edge when valid && ready here.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_err) fe_seen++;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", out_fields(), '0);
        end else begin
          chk("out_point", out_fields(), exp_q.pop_front());
          exp_pc = (exp_pc + 1) % (1 << PT_W);
        end
      end
    end
  end

  task automatic send_beat(input logic [31:0] d, input logic l);
    int   n;
    logic rdy;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    bus.in_last  = l;
    n = 0;
    do begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 50);
    if (!rdy) chk("beat_accept_timeout", {127'd0, rdy}, 128'd1);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_point(input point_t p, input bit expect_out);
    logic [127:0] w;
    w = p;
    for (int i = 0; i < 4; i++) begin
      if (i == 3 && expect_out) exp_q.push_back(p);
      send_beat(w[127-32*i -: 32], (i == 3));
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    point_t p1, pa, pb, pc;
    int     fe0, c0, n;

    rst_n         = 1'b0;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    tick(3);
    chk("reset_outputs", {out_fields(), bus.out_valid, frame_err, err_count, point_count, drop_count},
        '0);
    chk("reset_in_ready", {127'd0, bus.in_ready}, 128'd1);
    rst_n = 1'b1;
    tick(1);

    // Basic point, consumer always ready.
    p1 = '{x: 32'd1, y: 32'd2, z: 32'd3, r: 8'hAA, g: 8'hBB, b: 8'hCC, intensity: 8'hDD};
    send_point(p1, 1'b1);
    chk("p1_valid", {127'd0, bus.out_valid}, 128'd1);
    chk("p1_fields", out_fields(), p1);
    tick(1);
    chk("p1_cleared", {127'd0, bus.out_valid}, 128'd0);
    chk("p1_count", {{(128-PT_W){1'b0}}, point_count}, 128'd1);

    // Back-pressure: second point's last beat stalls behind the held output.
    bus.out_ready = 1'b0;
    pa = p1;
    pb = '{x: 32'h8000_0000, y: 32'h7FFF_FFFF, z: 32'hDEAD_BEEF, r: 8'h01, g: 8'h02, b: 8'h03,
           intensity: 8'h04};
    send_point(pa, 1'b1);
    send_beat(pb.x, 1'b0);
    send_beat(pb.y, 1'b0);
    send_beat(pb.z, 1'b0);
    exp_q.push_back(pb);
    bus.in_data  = {pb.r, pb.g, pb.b, pb.intensity};
    bus.in_valid = 1'b1;
    bus.in_last  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_in_ready", {127'd0, bus.in_ready}, 128'd0);
      chk("stall_fields", out_fields(), pa);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    #1;
    chk("release_in_ready", {127'd0, bus.in_ready}, 128'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    chk("pb_valid", {127'd0, bus.out_valid}, 128'd1);
    chk("pb_fields", out_fields(), pb);
    tick(1);
    chk("pb_count", {{(128-PT_W){1'b0}}, point_count}, 128'd3);

    // Short frame: last on beat 2.
    fe0 = fe_seen;
    send_beat(32'h11, 1'b0);
    send_beat(32'h22, 1'b1);
    chk("short_pulse", {127'd0, frame_err}, 128'd1);
    chk("short_errcnt", {{(128-ERR_W){1'b0}}, err_count}, 128'd1);
    tick(1);
    chk("short_pulse_end", {127'd0, frame_err}, 128'd0);
    chk("short_no_out", {127'd0, bus.out_valid}, 128'd0);
    pc = '{x: 32'h10, y: 32'h20, z: 32'h30, r: 8'h40, g: 8'h50, b: 8'h60, intensity: 8'h70};
    send_point(pc, 1'b1);
    chk("after_short_fields", out_fields(), pc);
    tick(1);

    // Long frame: 5 beats without last, then last; one error, then resync.
    fe0 = fe_seen;
    for (int i = 0; i < 5; i++) send_beat(32'h100 + i, 1'b0);
    send_beat(32'h1FF, 1'b1);
    tick(2);
    chk("long_one_pulse", 128'(fe_seen - fe0), 128'd1);
    chk("long_errcnt", {{(128-ERR_W){1'b0}}, err_count}, 128'd2);
    chk("long_no_out", {127'd0, bus.out_valid}, 128'd0);
    send_point(p1, 1'b1);
    chk("after_long_fields", out_fields(), p1);
    tick(1);

    // 256 single-beat frames saturate the error counter.
    fe0 = fe_seen;
    for (int i = 0; i < 256; i++) send_beat(32'(i), 1'b1);
    tick(2);
    chk("err_saturated", {{(128-ERR_W){1'b0}}, err_count}, 128'hFF);
    chk("err_pulses", 128'(fe_seen - fe0), 128'd256);

    // Sustained throughput: 8 points in 32 cycles.
    c0 = cyc;
    for (int i = 0; i < 8; i++) begin
      pc = point_t'({32'(i), ~32'(i), 32'(i * 3), 32'(i ^ 32'h5A5A_5A5A)});
      send_point(pc, 1'b1);
    end
    chk("throughput_cycles", 128'(cyc - c0), 128'd32);
    tick(2);
    chk("pc_model", {{(128-PT_W){1'b0}}, point_count}, 128'(exp_pc));

    // Wrap the point counter to land on 1.
    n = (1 << PT_W) + 1 - exp_pc;
    for (int i = 0; i < n; i++) begin
      pc = point_t'({32'(i + 100), 32'(i), 32'(i + 7), 32'(i * 5)});
      send_point(pc, 1'b1);
    end
    tick(2);
    chk("pc_wrap", {{(128-PT_W){1'b0}}, point_count}, 128'd1);

`ifdef POINT_PARSER_RANGE_CHECK_EN
    pc = '{x: 32'h0020_0000, y: 32'd0, z: 32'd0, r: 8'd1, g: 8'd2, b: 8'd3, intensity: 8'd4};
    send_point(pc, 1'b0);
    chk("range_drop_valid", {127'd0, bus.out_valid}, 128'd0);
    chk("range_drop_cnt", {112'd0, drop_count}, 128'd1);
    pc.x = 32'h0010_0000;
    send_point(pc, 1'b1);
    chk("range_edge_fields", out_fields(), pc);
    tick(1);
    pc.x = 32'd0;
    pc.z = 32'h8000_0000;
    send_point(pc, 1'b0);
    chk("range_min_neg_cnt", {112'd0, drop_count}, 128'd2);
    tick(1);
`endif

    // Reset in the middle of a point.
    send_beat(32'hDEAD_0001, 1'b0);
    send_beat(32'hDEAD_0002, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midreset_outputs",
        {out_fields(), bus.out_valid, frame_err, err_count, point_count, drop_count}, '0);
    exp_pc = 0;
    tick(1);
    rst_n = 1'b1;
    tick(1);
    send_point(p1, 1'b1);
    chk("post_reset_fields", out_fields(), p1);
    chk("post_reset_err", {{(128-ERR_W){1'b0}}, err_count}, 128'd0);
    tick(2);
    chk("post_reset_count", {{(128-PT_W){1'b0}}, point_count}, 128'd1);
    chk("queue_drained", 128'(exp_q.size()), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
